iobuff_bank: RTL and testbench

Parametrised bank of per-channel IO buffer controllers driving the 74LVC1T45 direction pin, the 74LVC1G07 open-drain pin and the FPGA tristate data pin of each Bus Pirate IO line. It generalises the single-channel combinational buffer driver to CHANNELS lanes. Each lane has a registered mode state machine with break-before-make direction turnaround, so the FPGA pin and the level translator never drive against each other. The bank sits between the protocol engines and the top-level SB_IO tristate array and returns synchronised pin input data to the engines.

---
 rtl/iobuff_bank.sv | 151 +++++++++++++++
 tb/tb_iobuff_bank.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/iobuff_bank.sv
// iobuff_bank: bank of per-lane IO buffer controllers for the Bus Pirate IO lines.
// Each lane owns a small mode FSM that sequences the level translator direction
// pin and the FPGA tristate enable with a break-before-make dead time, so the
// FPGA pin and the translator never drive against each other.
module iobuff_bank #(
  parameter int CHANNELS    = 4,
  parameter int TURN_CYCLES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] oe,
  input  logic [CHANNELS-1:0] od,
  input  logic [CHANNELS-1:0] dir,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] bufdir,
  output logic [CHANNELS-1:0] bufod,
  output logic [CHANNELS-1:0] bufdat_oe,
  output logic [CHANNELS-1:0] bufdat_dout,
  input  logic [CHANNELS-1:0] bufdat_din
);

  localparam logic [2:0] S_IN     = 3'd0;
  localparam logic [2:0] S_TO_OUT = 3'd1;
  localparam logic [2:0] S_OUT    = 3'd2;
  localparam logic [2:0] S_TO_IN  = 3'd3;
  localparam logic [2:0] S_OD     = 3'd4;

  localparam logic [7:0] TURN_LOAD = 8'(TURN_CYCLES);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic [2:0]             state_r;
    logic [2:0]             state_next_s;
    logic [7:0]             cnt_r;
    logic [7:0]             cnt_next_s;
    logic                   din_q_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   bufdir_r;
    logic                   bufdat_oe_r;
    logic                   bufod_r;
    logic                   bufdat_dout_r;
    logic                   busy_r;
    logic                   tgt_pp_s;
    logic                   tgt_od_s;

    // Requested lane mode; anything that is neither push-pull nor open-drain is input.
    assign tgt_pp_s = oe[i] & ~od[i] & ~dir[i];
    assign tgt_od_s = oe[i] & od[i];

    // Next-state and dead-time counter logic; turn states always run to completion.
    always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      case (state_r)
        S_IN: begin
          if (tgt_pp_s) begin
            state_next_s = S_TO_OUT;
            cnt_next_s   = TURN_LOAD;
          end else if (tgt_od_s) begin
            state_next_s = S_OD;
          end else begin
            state_next_s = S_IN;
          end
        end
        S_TO_OUT: begin
          if (cnt_r == 8'd0) begin
            state_next_s = S_OUT;
          end else begin
            cnt_next_s = cnt_r - 8'd1;
          end
        end
        S_OUT: begin
          if (!tgt_pp_s) begin
            state_next_s = S_TO_IN;
            cnt_next_s   = TURN_LOAD;
          end else begin
            state_next_s = S_OUT;
          end
        end
        S_TO_IN: begin
          if (cnt_r == 8'd0) begin
            state_next_s = S_IN;
          end else begin
            cnt_next_s = cnt_r - 8'd1;
          end
        end
        S_OD: begin
          if (!tgt_od_s) begin
            state_next_s = S_IN;
          end else begin
            state_next_s = S_OD;
          end
        end
        default: begin
          // Unreachable encodings fall back to the safe input mode.
          state_next_s = S_IN;
          cnt_next_s   = 8'd0;
        end
      endcase
    end

    // State, counter and data-input registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= S_IN;
        cnt_r   <= 8'd0;
        din_q_r <= 1'b0;
      end else begin
        state_r <= state_next_s;
        cnt_r   <= cnt_next_s;
        din_q_r <= din[i];
      end
    end

    // Registered pin controls decoded from the current state.
    always_ff @(posedge clk) begin
      if (rst) begin
        bufdir_r      <= 1'b0;
        bufdat_oe_r   <= 1'b0;
        bufod_r       <= 1'b1;
        bufdat_dout_r <= 1'b0;
        busy_r        <= 1'b0;
      end else begin
        bufdir_r      <= (state_r == S_TO_OUT) || (state_r == S_OUT) || (state_r == S_TO_IN);
        bufdat_oe_r   <= (state_r == S_OUT);
        bufod_r       <= (state_r == S_OD) ? din_q_r : 1'b1;
        bufdat_dout_r <= din_q_r;
        busy_r        <= (state_r == S_TO_OUT) || (state_r == S_TO_IN);
      end
    end

    // Pin input synchroniser, active in every state so a driven lane reads itself back.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_r <= '0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], bufdat_din[i]};
      end
    end

    assign bufdir[i]      = bufdir_r;
    assign bufdat_oe[i]   = bufdat_oe_r;
    assign bufod[i]       = bufod_r;
    assign bufdat_dout[i] = bufdat_dout_r;
    assign busy[i]        = busy_r;
    assign dout[i]        = sync_r[SYNC_STAGES-1];
  end

endmodule

// File: tb/tb_iobuff_bank.sv
// tb_iobuff_bank: directed vector table plus hand sequences and a randomised
// safety-invariant run for iobuff_bank (CHANNELS=4, TURN_CYCLES=4, SYNC_STAGES=2).
module tb_iobuff_bank;
  localparam int TC = 4;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] oe, od, dir, din, bufdat_din;
  logic [3:0] dout, busy, bufdir, bufod, bufdat_oe, bufdat_dout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] oe, od, dir, din, bdin;
    logic [3:0] e_dir, e_doe, e_od, e_busy, e_dout, e_bdout;
  } vec_t;

  vec_t vq[$];

  iobuff_bank #(.CHANNELS(4), .TURN_CYCLES(TC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .oe(oe), .od(od), .dir(dir), .din(din),
    .dout(dout), .busy(busy), .bufdir(bufdir), .bufod(bufod),
    .bufdat_oe(bufdat_oe), .bufdat_dout(bufdat_dout), .bufdat_din(bufdat_din)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] a, b, c, d, e,
                     input logic [3:0] xd, xo, xp, xb, xi, xq);
    vec_t v;
    v.rst = r; v.oe = a; v.od = b; v.dir = c; v.din = d; v.bdin = e;
    v.e_dir = xd; v.e_doe = xo; v.e_od = xp; v.e_busy = xb; v.e_dout = xi; v.e_bdout = xq;
    vq.push_back(v);
  endtask

  int         rise_at[4];
  int         fall_at[4];
  logic [3:0] pdir, pdoe, viol;

  initial begin
    rst = 1'b1; oe = 4'h0; od = 4'h0; dir = 4'h0; din = 4'h0; bufdat_din = 4'h0;

    // rst oe od dir din bdin | bufdir bufdat_oe bufod busy dout bufdat_dout
    add(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 3; k++)
      add(1'b1, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF,  4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    // lane 0 push-pull turn-on; lane 2 requests output but is forced to input by dir
    add(1'b0, 4'h5, 4'h0, 4'h4, 4'h0, 4'h0,  4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 5; k++)
      add(1'b0, 4'h5, 4'h0, 4'h4, 4'h0, 4'h0,  4'h1, 4'h0, 4'hF, 4'h1, 4'h0, 4'h0);
    add(1'b0, 4'h5, 4'h0, 4'h4, 4'h0, 4'h0,  4'h1, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0);
    // lane 0 turn-off
    add(1'b0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0,  4'h1, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 5; k++)
      add(1'b0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0,  4'h1, 4'h0, 4'hF, 4'h1, 4'h0, 4'h0);
    add(1'b0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0,  4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    // lane 1 open-drain, din 1,0,1,0; lane 3 pin input pulse for the synchroniser
    add(1'b0, 4'h2, 4'h2, 4'h0, 4'h2, 4'h8,  4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1'b0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'hF, 4'h0, 4'h8, 4'h2);
    add(1'b0, 4'h2, 4'h2, 4'h0, 4'h2, 4'h0,  4'h0, 4'h0, 4'hD, 4'h0, 4'h0, 4'h0);
    add(1'b0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h2);
    // lane 1 od dropped: back to input, then push-pull turn-on
    add(1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'hD, 4'h0, 4'h0, 4'h0);
    add(1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 5; k++)
      add(1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0,  4'h2, 4'h0, 4'hF, 4'h2, 4'h0, 4'h0);
    add(1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0,  4'h2, 4'h2, 4'hF, 4'h0, 4'h0, 4'h0);

    foreach (vq[k]) begin
      rst = vq[k].rst; oe = vq[k].oe; od = vq[k].od; dir = vq[k].dir;
      din = vq[k].din; bufdat_din = vq[k].bdin;
      step();
      chk($sformatf("vec%0d", k),
          {8'h00, bufdir, bufdat_oe, bufod, busy, dout, bufdat_dout},
          {8'h00, vq[k].e_dir, vq[k].e_doe, vq[k].e_od, vq[k].e_busy, vq[k].e_dout, vq[k].e_bdout});
    end

    // Lane 2: request toggled mid-turn; the turn still completes into S_OUT.
    rst = 1'b1; oe = 4'h0; od = 4'h0; dir = 4'h0; din = 4'h0; bufdat_din = 4'h0;
    step();
    rst = 1'b0; oe = 4'h4;
    step();                                   // edge 0: target sampled
    oe = 4'h0; step();                        // edge 1
    chk("l2_dir_e1", {30'd0, bufdir[2], busy[2]}, 32'd3);
    oe = 4'h4; step();                        // edge 2
    oe = 4'h0;
    for (int k = 3; k <= TC + 1; k++) begin
      step();
      chk($sformatf("l2_busy_e%0d", k), {30'd0, busy[2], bufdat_oe[2]}, 32'd2);
    end
    step();                                   // edge TC+2: S_OUT reached
    chk("l2_out", {29'd0, bufdir[2], bufdat_oe[2], busy[2]}, 32'd6);
    step();                                   // S_TO_IN starts the edge after
    chk("l2_to_in", {29'd0, bufdir[2], bufdat_oe[2], busy[2]}, 32'd5);
    for (int k = 0; k < TC; k++) step();
    chk("l2_dir_hold", {31'd0, bufdir[2]}, 32'd1);
    step();
    chk("l2_in", {29'd0, bufdir[2], bufdat_oe[2], busy[2]}, 32'd0);

    // Reset while lane 3 is in S_OUT and lane 0 is in S_TO_OUT.
    oe = 4'h8;
    for (int k = 0; k < TC + 2; k++) step();
    oe = 4'h9;
    step();
    step();
    chk("pre_rst", {26'd0, bufdat_oe[3], bufdir[3], busy[0], bufdir[0], bufdat_oe[0], busy[3]}, 32'h3C);
    rst = 1'b1;
    step();
    chk("rst_mid", {20'd0, bufdir, bufdat_oe, busy}, 32'h000);
    chk("rst_mid_od", {28'd0, bufod}, 32'hF);
    rst = 1'b0; oe = 4'h0;
    step();
    chk("rst_after", {20'd0, bufdir, bufdat_oe, busy}, 32'h000);

    // Input synchroniser latency.
    bufdat_din = 4'h5;
    for (int k = 0; k < SS + 1; k++) step();
    chk("sync_pre", {28'd0, dout}, 32'h5);
    bufdat_din = 4'hA;
    for (int k = 1; k < SS; k++) begin
      step();
      chk($sformatf("sync_hold%0d", k), {28'd0, dout}, 32'h5);
    end
    step();
    chk("sync_lat", {28'd0, dout}, 32'hA);

    // Randomised run: safety invariants and exact turnaround spacing.
    rst = 1'b1; step(); rst = 1'b0;
    pdir = bufdir; pdoe = bufdat_oe;
    for (int l = 0; l < 4; l++) begin rise_at[l] = -100; fall_at[l] = -100; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      oe = 4'($urandom); od = 4'($urandom); dir = 4'($urandom);
      din = 4'($urandom); bufdat_din = 4'($urandom);
      step();
      viol = (~bufdir & bufdat_oe) | (~bufod & bufdir) | (busy & (bufdat_oe | ~bufdir));
      chk($sformatf("invariant_c%0d", cyc), {28'd0, viol}, 32'd0);
      for (int l = 0; l < 4; l++) begin
        if (bufdir[l] && !pdir[l]) rise_at[l] = cyc;
        if (!bufdat_oe[l] && pdoe[l]) fall_at[l] = cyc;
        if (bufdat_oe[l] && !pdoe[l])
          chk($sformatf("make_gap_l%0d", l), 32'(cyc - rise_at[l]), 32'(TC + 1));
        if (!bufdir[l] && pdir[l])
          chk($sformatf("break_gap_l%0d", l), 32'(cyc - fall_at[l]), 32'(TC + 1));
      end
      pdir = bufdir; pdoe = bufdat_oe;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
